axi_cdc_src_isolate: RTL and testbench



---
 rtl/axi_cdc_src_isolate_pkg.sv | 50 +++++
 rtl/axi_cdc_src_isolate_cnt.sv | 50 +++++
 rtl/axi_cdc_src_isolate.sv | 118 +++++++++++
 tb/tb_axi_cdc_src_isolate.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_cdc_src_isolate_pkg.sv
// Default AXI channel and request/response structs for the CDC source isolation block.
// Integrators normally override the types with their own platform structs.
package axi_cdc_src_isolate_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } axi_rsp_t;

endpackage

// File: rtl/axi_cdc_src_isolate_cnt.sv
// Outstanding-burst up/down counter with saturation/zero flags.
// Net overflow or underflow is a protocol error: flagged, and the count holds.
module axi_cdc_src_isolate_cnt #(
    parameter int unsigned MaxTxns = 8,
    localparam int unsigned CntW   = $clog2(MaxTxns + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            inc_i,
    input  logic            dec_i,
    output logic [CntW-1:0] cnt_o,
    output logic            sat_o,
    output logic            zero_o
);

    localparam logic [CntW-1:0] MaxVal = CntW'(MaxTxns);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && (cnt_q != MaxVal)) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (dec_i && !inc_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign sat_o  = (cnt_q == MaxVal);
    assign zero_o = (cnt_q == '0);

`ifndef SYNTHESIS
    a_no_overflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(inc_i && !dec_i && sat_o))
        else $error("outstanding counter overflow");
    a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(dec_i && !inc_i && zero_o))
        else $error("outstanding counter underflow");
`endif

endmodule

// File: rtl/axi_cdc_src_isolate.sv
// Source-domain isolation in front of the AXI CDC: stops new bursts, drains
// outstanding responses, then reports the crossing quiescent. Pass-through otherwise.
module axi_cdc_src_isolate #(
    parameter int unsigned MaxTxns = 8,
    parameter type axi_req_t = axi_cdc_src_isolate_pkg::axi_req_t,
    parameter type axi_rsp_t = axi_cdc_src_isolate_pkg::axi_rsp_t
) (
    input  logic     src_clk_i,
    input  logic     src_rst_ni,
    input  axi_req_t slv_req_i,
    output axi_rsp_t slv_rsp_o,
    output axi_req_t mst_req_o,
    input  axi_rsp_t mst_rsp_i,
    input  logic     isolate_i,
    output logic     isolated_o
);

    localparam int unsigned CntW = $clog2(MaxTxns + 1);

    typedef enum logic [1:0] {NORMAL, DRAIN, ISOLATED} state_e;

    state_e          state_q, state_d;
    logic            aw_pend_q, aw_pend_d, ar_pend_q, ar_pend_d;
    logic [CntW-1:0] wr_cnt, rd_cnt;
    logic            wr_sat, rd_sat, wr_zero, rd_zero;
    logic            aw_gate, ar_gate, w_gate;
    logic            aw_hs, ar_hs, b_hs, r_last_hs;

    // Accounting is taken on the CDC side of the gate, so blocked bursts never count.
    assign aw_hs     = mst_req_o.aw_valid & mst_rsp_i.aw_ready;
    assign ar_hs     = mst_req_o.ar_valid & mst_rsp_i.ar_ready;
    assign b_hs      = mst_rsp_i.b_valid & slv_req_i.b_ready;
    assign r_last_hs = mst_rsp_i.r_valid & slv_req_i.r_ready & mst_rsp_i.r.last;

    assign aw_pend_d = mst_req_o.aw_valid & ~mst_rsp_i.aw_ready;
    assign ar_pend_d = mst_req_o.ar_valid & ~mst_rsp_i.ar_ready;

    axi_cdc_src_isolate_cnt #(.MaxTxns(MaxTxns)) i_wr_cnt (
        .clk_i  (src_clk_i),
        .rst_ni (src_rst_ni),
        .inc_i  (aw_hs),
        .dec_i  (b_hs),
        .cnt_o  (wr_cnt),
        .sat_o  (wr_sat),
        .zero_o (wr_zero)
    );

    axi_cdc_src_isolate_cnt #(.MaxTxns(MaxTxns)) i_rd_cnt (
        .clk_i  (src_clk_i),
        .rst_ni (src_rst_ni),
        .inc_i  (ar_hs),
        .dec_i  (r_last_hs),
        .cnt_o  (rd_cnt),
        .sat_o  (rd_sat),
        .zero_o (rd_zero)
    );

    always_ff @(posedge src_clk_i or negedge src_rst_ni) begin
        if (!src_rst_ni) begin
            state_q   <= NORMAL;
            aw_pend_q <= 1'b0;
            ar_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_pend_q <= aw_pend_d;
            ar_pend_q <= ar_pend_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NORMAL: begin
                if (isolate_i) state_d = DRAIN;
            end
            DRAIN: begin
                if (!isolate_i) begin
                    state_d = NORMAL;
                end else if (wr_zero && rd_zero && !aw_pend_q && !ar_pend_q) begin
                    state_d = ISOLATED;
                end
            end
            ISOLATED: begin
                if (!isolate_i) state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    // A valid already presented to the CDC is never withdrawn, whatever the state.
    always_comb begin
        aw_gate = ((state_q != NORMAL) || wr_sat) && !aw_pend_q;
        ar_gate = ((state_q != NORMAL) || rd_sat) && !ar_pend_q;
        w_gate  = (state_q == ISOLATED);

        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & ~aw_gate;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ~ar_gate;
        mst_req_o.w_valid  = slv_req_i.w_valid & ~w_gate;

        slv_rsp_o          = mst_rsp_i;
        slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & ~aw_gate;
        slv_rsp_o.ar_ready = mst_rsp_i.ar_ready & ~ar_gate;
        slv_rsp_o.w_ready  = mst_rsp_i.w_ready & ~w_gate;

        isolated_o = (state_q == ISOLATED);
    end

`ifndef SYNTHESIS
    a_aw_pend_held : assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        aw_pend_q |-> slv_req_i.aw_valid)
        else $error("pending AW valid withdrawn by upstream master");
    a_ar_pend_held : assert property (@(posedge src_clk_i) disable iff (!src_rst_ni)
        ar_pend_q |-> slv_req_i.ar_valid)
        else $error("pending AR valid withdrawn by upstream master");
`endif

endmodule

// File: tb/tb_axi_cdc_src_isolate.sv
// Directed bench for axi_cdc_src_isolate (MaxTxns=2) with a queue-based channel scoreboard.
module tb_axi_cdc_src_isolate;
    import axi_cdc_src_isolate_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n;
    axi_req_t slv_req, mst_req;
    axi_rsp_t slv_rsp, mst_rsp;
    logic     isolate, isolated;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] exp_aw[$], exp_ar[$], exp_w[$], exp_r[$];
    logic [3:0]  exp_b[$];

    always #5 clk = ~clk;

    axi_cdc_src_isolate #(
        .MaxTxns   (2),
        .axi_req_t (axi_req_t),
        .axi_rsp_t (axi_rsp_t)
    ) dut (
        .src_clk_i  (clk),
        .src_rst_ni (rst_n),
        .slv_req_i  (slv_req),
        .slv_rsp_o  (slv_rsp),
        .mst_req_o  (mst_req),
        .mst_rsp_i  (mst_rsp),
        .isolate_i  (isolate),
        .isolated_o (isolated)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: handshake seen, want none (scoreboard empty)", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every forwarded handshake must match the next expected entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mst_req.aw_valid && mst_rsp.aw_ready) begin
                if (exp_aw.size() == 0) unexpected("sb_aw");
                else check("sb_aw_addr", mst_req.aw.addr, exp_aw.pop_front());
            end
            if (mst_req.ar_valid && mst_rsp.ar_ready) begin
                if (exp_ar.size() == 0) unexpected("sb_ar");
                else check("sb_ar_addr", mst_req.ar.addr, exp_ar.pop_front());
            end
            if (mst_req.w_valid && mst_rsp.w_ready) begin
                if (exp_w.size() == 0) unexpected("sb_w");
                else check("sb_w_data", mst_req.w.data, exp_w.pop_front());
            end
            if (slv_rsp.b_valid && slv_req.b_ready) begin
                if (exp_b.size() == 0) unexpected("sb_b");
                else check("sb_b_id", slv_rsp.b.id, exp_b.pop_front());
            end
            if (slv_rsp.r_valid && slv_req.r_ready) begin
                if (exp_r.size() == 0) unexpected("sb_r");
                else check("sb_r_data", slv_rsp.r.data, exp_r.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        slv_req = '0;
        mst_rsp = '0;
        isolate = 1'b0;
        rst_n   = 1'b0;
        mst_rsp.aw_ready = 1'b1;
        mst_rsp.w_ready  = 1'b1;
        mst_rsp.ar_ready = 1'b1;
        slv_req.b_ready  = 1'b1;
        slv_req.r_ready  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_isolated", isolated, 0);
        check("rst_wr_cnt", dut.wr_cnt, 0);
        check("rst_rd_cnt", dut.rd_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Pass-through writes and reads
        for (int i = 0; i < 3; i++) begin
            slv_req.aw.addr  = 32'h1000 + 32'(i) * 16;
            slv_req.aw.id    = 4'(i);
            slv_req.aw_valid = 1'b1;
            exp_aw.push_back(32'h1000 + 32'(i) * 16);
            #1;
            check("pt_aw_valid", mst_req.aw_valid, 1);
            check("pt_aw_ready", slv_rsp.aw_ready, 1);
            tick();
            slv_req.aw_valid = 1'b0;
            slv_req.w.data   = 32'hA0 + 32'(i);
            slv_req.w.last   = 1'b1;
            slv_req.w_valid  = 1'b1;
            exp_w.push_back(32'hA0 + 32'(i));
            tick();
            slv_req.w_valid  = 1'b0;
            mst_rsp.b.id     = 4'(i);
            mst_rsp.b_valid  = 1'b1;
            exp_b.push_back(4'(i));
            tick();
            mst_rsp.b_valid  = 1'b0;
        end
        #1;
        check("pt_wr_cnt", dut.wr_cnt, 0);
        for (int j = 0; j < 2; j++) begin
            slv_req.ar.addr  = 32'h2000 + 32'(j) * 32;
            slv_req.ar_valid = 1'b1;
            exp_ar.push_back(32'h2000 + 32'(j) * 32);
            #1;
            check("pt_ar_valid", mst_req.ar_valid, 1);
            tick();
            slv_req.ar_valid = 1'b0;
            mst_rsp.r.data   = 32'hD0 + 32'(j);
            mst_rsp.r.last   = 1'b1;
            mst_rsp.r_valid  = 1'b1;
            exp_r.push_back(32'hD0 + 32'(j));
            tick();
            mst_rsp.r_valid  = 1'b0;
        end
        #1;
        check("pt_rd_cnt", dut.rd_cnt, 0);

        // Drain with two writes outstanding
        slv_req.aw_valid = 1'b1;
        slv_req.aw.addr  = 32'h3000;
        exp_aw.push_back(32'h3000);
        tick();
        slv_req.aw.addr  = 32'h3010;
        exp_aw.push_back(32'h3010);
        tick();
        slv_req.aw_valid = 1'b0;
        isolate = 1'b1;
        tick();
        slv_req.aw.addr  = 32'h3F00;
        slv_req.aw_valid = 1'b1;
        slv_req.ar.addr  = 32'h4F00;
        slv_req.ar_valid = 1'b1;
        #1;
        check("drain_aw_ready", slv_rsp.aw_ready, 0);
        check("drain_aw_valid", mst_req.aw_valid, 0);
        check("drain_ar_ready", slv_rsp.ar_ready, 0);
        check("drain_ar_valid", mst_req.ar_valid, 0);
        tick();
        check("drain_aw_ready2", slv_rsp.aw_ready, 0);
        slv_req.aw_valid = 1'b0;
        slv_req.ar_valid = 1'b0;
        slv_req.w.data   = 32'h31;
        slv_req.w_valid  = 1'b1;
        exp_w.push_back(32'h31);
        #1;
        check("drain_w_valid", mst_req.w_valid, 1);
        tick();
        slv_req.w.data   = 32'h32;
        exp_w.push_back(32'h32);
        tick();
        slv_req.w_valid  = 1'b0;
        mst_rsp.b.id     = 4'd5;
        mst_rsp.b_valid  = 1'b1;
        exp_b.push_back(4'd5);
        tick();
        mst_rsp.b_valid  = 1'b0;
        check("drain_iso_b1", isolated, 0);
        mst_rsp.b.id     = 4'd6;
        mst_rsp.b_valid  = 1'b1;
        exp_b.push_back(4'd6);
        tick();
        mst_rsp.b_valid  = 1'b0;
        check("drain_iso_early", isolated, 0);
        tick();
        check("drain_iso", isolated, 1);
        slv_req.w_valid  = 1'b1;
        #1;
        check("iso_w_valid", mst_req.w_valid, 0);
        check("iso_w_ready", slv_rsp.w_ready, 0);
        slv_req.w_valid  = 1'b0;
        isolate = 1'b0;
        #1;
        check("iso_hold", isolated, 1);
        tick();
        check("iso_fall", isolated, 0);

        // Pending AW valid at isolate request
        mst_rsp.aw_ready = 1'b0;
        slv_req.aw.addr  = 32'h5000;
        slv_req.aw_valid = 1'b1;
        exp_aw.push_back(32'h5000);
        tick();
        isolate = 1'b1;
        tick();
        check("pend_aw_valid", mst_req.aw_valid, 1);
        tick();
        check("pend_aw_valid2", mst_req.aw_valid, 1);
        check("pend_iso", isolated, 0);
        mst_rsp.aw_ready = 1'b1;
        #1;
        check("pend_aw_ready", slv_rsp.aw_ready, 1);
        tick();
        slv_req.aw_valid = 1'b0;
        tick();
        check("pend_iso_wait", isolated, 0);
        mst_rsp.b.id     = 4'd7;
        mst_rsp.b_valid  = 1'b1;
        exp_b.push_back(4'd7);
        tick();
        mst_rsp.b_valid  = 1'b0;
        check("pend_iso_b", isolated, 0);
        tick();
        check("pend_iso", isolated, 1);
        isolate = 1'b0;
        tick();

        // Read saturation at MaxTxns=2
        slv_req.ar_valid = 1'b1;
        slv_req.ar.addr  = 32'h6000;
        exp_ar.push_back(32'h6000);
        tick();
        slv_req.ar.addr  = 32'h6010;
        exp_ar.push_back(32'h6010);
        tick();
        slv_req.ar.addr  = 32'h6020;
        #1;
        check("sat_ar_ready", slv_rsp.ar_ready, 0);
        check("sat_ar_valid", mst_req.ar_valid, 0);
        tick();
        check("sat_ar_ready2", slv_rsp.ar_ready, 0);
        mst_rsp.r.data   = 32'hE0;
        mst_rsp.r.last   = 1'b1;
        mst_rsp.r_valid  = 1'b1;
        exp_r.push_back(32'hE0);
        #1;
        check("sat_same_cycle", slv_rsp.ar_ready, 0);
        tick();
        mst_rsp.r_valid  = 1'b0;
        #1;
        check("sat_unblock", mst_req.ar_valid, 1);
        exp_ar.push_back(32'h6020);
        tick();
        slv_req.ar_valid = 1'b0;
        mst_rsp.r.data   = 32'hE1;
        mst_rsp.r.last   = 1'b0;
        mst_rsp.r_valid  = 1'b1;
        exp_r.push_back(32'hE1);
        tick();
        check("sat_nolast_cnt", dut.rd_cnt, 2);
        mst_rsp.r.data   = 32'hE2;
        mst_rsp.r.last   = 1'b1;
        exp_r.push_back(32'hE2);
        tick();
        mst_rsp.r.data   = 32'hE3;
        exp_r.push_back(32'hE3);
        tick();
        mst_rsp.r_valid  = 1'b0;
        check("sat_rd_cnt", dut.rd_cnt, 0);

        // Abort a drain with one read outstanding
        slv_req.ar.addr  = 32'h7000;
        slv_req.ar_valid = 1'b1;
        exp_ar.push_back(32'h7000);
        tick();
        slv_req.ar_valid = 1'b0;
        isolate = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("abort_iso", isolated, 0);
        end
        isolate = 1'b0;
        tick();
        slv_req.ar.addr  = 32'h7100;
        slv_req.ar_valid = 1'b1;
        exp_ar.push_back(32'h7100);
        #1;
        check("abort_ar_valid", mst_req.ar_valid, 1);
        check("abort_ar_ready", slv_rsp.ar_ready, 1);
        tick();
        slv_req.ar_valid = 1'b0;
        mst_rsp.r.last   = 1'b1;
        mst_rsp.r.data   = 32'hE4;
        mst_rsp.r_valid  = 1'b1;
        exp_r.push_back(32'hE4);
        tick();
        mst_rsp.r.data   = 32'hE5;
        exp_r.push_back(32'hE5);
        tick();
        mst_rsp.r_valid  = 1'b0;
        check("abort_iso_end", isolated, 0);
        check("abort_rd_cnt", dut.rd_cnt, 0);

        // Asynchronous reset while isolated
        isolate = 1'b1;
        tick();
        tick();
        check("rst_pre_iso", isolated, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", isolated, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_drain", isolated, 0);
        tick();
        check("rst_reiso", isolated, 1);
        isolate = 1'b0;
        tick();
        check("rst_fall", isolated, 0);

        check("sb_aw_left", 64'(exp_aw.size()), 0);
        check("sb_ar_left", 64'(exp_ar.size()), 0);
        check("sb_w_left", 64'(exp_w.size()), 0);
        check("sb_b_left", 64'(exp_b.size()), 0);
        check("sb_r_left", 64'(exp_r.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
